// File: rtl/rtc_access_scheduler.sv
// Batches RTC register transfers: arbitrates periodic read batches against
// level write requests, walks NREG addresses and abandons a stalled transfer.
module rtc_access_scheduler #(
   parameter int unsigned NREG      = 6,
   parameter logic [7:0]  BASE_ADDR = 8'h21,
   parameter int unsigned TMO       = 31
)(
   input  logic       clkCL,
   input  logic       resetCL,
   input  logic       tick_rd,
   input  logic       wr_req,
   input  logic       seq_done,
   output logic       en_rd,
   output logic       en_wr,
   output logic [7:0] reg_addr,
   output logic       busy,
   output logic       rd_valid,
   output logic       wr_ack,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, RD_XFER, RD_GAP, WR_XFER, WR_GAP} state_t;

   localparam logic [3:0] LAST_IDX = 4'(NREG - 1);
   localparam logic [5:0] TMO_LAST = 6'(TMO - 1);

   state_t     state, stateNxt;
   logic [3:0] idx, idxNxt;
   logic [5:0] tmoCnt, tmoCntNxt;
   logic       pendRd, pendRdNxt;
   logic       rdValidNxt, wrAckNxt, errNxt;
   logic       inXfer, lastReg, tmoHit;

   assign inXfer  = (state == RD_XFER) || (state == WR_XFER);
   assign lastReg = (idx == LAST_IDX);
   // A completion arriving on the final allowed cycle wins over the timeout.
   assign tmoHit  = inXfer && !seq_done && (tmoCnt == TMO_LAST);

   always_comb begin
      stateNxt   = state;
      idxNxt     = idx;
      tmoCntNxt  = tmoCnt;
      pendRdNxt  = pendRd | tick_rd;
      rdValidNxt = 1'b0;
      wrAckNxt   = 1'b0;
      errNxt     = 1'b0;
      unique case (state)
         IDLE: begin
            if (wr_req) begin
               stateNxt  = WR_XFER;
               idxNxt    = 4'd0;
               tmoCntNxt = 6'd0;
            end else if (pendRd) begin
               // Ticks landing on the dispatch cycle collapse into this batch.
               stateNxt  = RD_XFER;
               idxNxt    = 4'd0;
               tmoCntNxt = 6'd0;
               pendRdNxt = 1'b0;
            end
         end
         RD_XFER, WR_XFER: begin
            if (seq_done) begin
               tmoCntNxt = 6'd0;
               if (lastReg) begin
                  stateNxt   = IDLE;
                  idxNxt     = 4'd0;
                  rdValidNxt = (state == RD_XFER);
                  wrAckNxt   = (state == WR_XFER);
               end else begin
                  stateNxt = (state == RD_XFER) ? RD_GAP : WR_GAP;
                  idxNxt   = idx + 4'd1;
               end
            end else if (tmoHit) begin
               stateNxt  = IDLE;
               idxNxt    = 4'd0;
               tmoCntNxt = 6'd0;
               errNxt    = 1'b1;
            end else begin
               tmoCntNxt = tmoCnt + 6'd1;
            end
         end
         RD_GAP: begin
            stateNxt  = RD_XFER;
            tmoCntNxt = 6'd0;
         end
         WR_GAP: begin
            stateNxt  = WR_XFER;
            tmoCntNxt = 6'd0;
         end
         default: begin
            stateNxt  = IDLE;
            idxNxt    = 4'd0;
            tmoCntNxt = 6'd0;
         end
      endcase
   end

   always_ff @(posedge clkCL or posedge resetCL) begin
      if (resetCL) begin
         state    <= IDLE;
         idx      <= 4'd0;
         tmoCnt   <= 6'd0;
         pendRd   <= 1'b0;
         rd_valid <= 1'b0;
         wr_ack   <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= stateNxt;
         idx      <= idxNxt;
         tmoCnt   <= tmoCntNxt;
         pendRd   <= pendRdNxt;
         rd_valid <= rdValidNxt;
         wr_ack   <= wrAckNxt;
         err      <= errNxt;
      end
   end

   assign en_rd    = (state == RD_XFER);
   assign en_wr    = (state == WR_XFER);
   assign busy     = (state != IDLE);
   assign reg_addr = BASE_ADDR + {4'd0, idx};

endmodule

// File: tb/tb_rtc_access_scheduler.sv
// Directed scenarios plus randomized traffic, all checked every cycle against
// a batch-level reference model of the scheduler.
module tb_rtc_access_scheduler;

   localparam int         NREG = 6;
   localparam logic [7:0] BASE = 8'h21;
   localparam int         TMO  = 31;

   logic       clkCL = 1'b0, resetCL = 1'b1;
   logic       tick_rd = 1'b0, wr_req = 1'b0, seq_done = 1'b0;
   logic       en_rd, en_wr, busy, rd_valid, wr_ack, err;
   logic [7:0] reg_addr;

   always #5 clkCL = ~clkCL;

   rtc_access_scheduler #(.NREG(NREG), .BASE_ADDR(BASE), .TMO(TMO)) dut (
      .clkCL(clkCL), .resetCL(resetCL), .tick_rd(tick_rd), .wr_req(wr_req),
      .seq_done(seq_done), .en_rd(en_rd), .en_wr(en_wr), .reg_addr(reg_addr),
      .busy(busy), .rd_valid(rd_valid), .wr_ack(wr_ack), .err(err));

   int nCmp = 0, nBad = 0;
   // model: mBatch 0=none 1=read 2=write; mGap = between registers
   int mBatch, mIdx, mWait, inX;
   bit mGap, mPend, mRv, mAck, mErr;
   int nRv, nAck, nErr, nEnRd, nEnWr;
   int addrQ[$];

   task automatic chk(input string nm, input int act, input int exp);
      nCmp++;
      if (act != exp) begin
         nBad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic void modelReset();
      mBatch = 0; mIdx = 0; mWait = 0; inX = 0;
      mGap = 0; mPend = 0; mRv = 0; mAck = 0; mErr = 0;
   endfunction

   function automatic void modelStep();
      bit np;
      np = mPend | tick_rd;
      mRv = 0; mAck = 0; mErr = 0;
      if (mBatch == 0) begin
         if (wr_req) begin
            mBatch = 2; mIdx = 0; mWait = 0; mGap = 0;
         end else if (mPend) begin
            mBatch = 1; mIdx = 0; mWait = 0; mGap = 0; np = 0;
         end
      end else if (mGap) begin
         mGap = 0; mWait = 0;
      end else if (seq_done) begin
         if (mIdx == NREG - 1) begin
            if (mBatch == 1) mRv = 1; else mAck = 1;
            mBatch = 0; mIdx = 0;
         end else begin
            mIdx++; mGap = 1;
         end
      end else begin
         mWait++;
         if (mWait == TMO) begin
            mErr = 1; mBatch = 0; mIdx = 0;
         end
      end
      mPend = np;
      if (mBatch != 0 && !mGap) inX++; else inX = 0;
   endfunction

   task automatic compare();
      chk("en_rd", int'(en_rd), int'(mBatch == 1 && !mGap));
      chk("en_wr", int'(en_wr), int'(mBatch == 2 && !mGap));
      chk("busy", int'(busy), int'(mBatch != 0));
      chk("reg_addr", int'(reg_addr), (int'(BASE) + mIdx) & 255);
      chk("rd_valid", int'(rd_valid), int'(mRv));
      chk("wr_ack", int'(wr_ack), int'(mAck));
      chk("err", int'(err), int'(mErr));
   endtask

   task automatic cyc();
      @(posedge clkCL);
      if (!resetCL) modelStep();
      @(negedge clkCL);
      compare();
      nRv += int'(rd_valid); nAck += int'(wr_ack); nErr += int'(err);
      nEnRd += int'(en_rd); nEnWr += int'(en_wr);
   endtask

   task automatic clrCnt();
      nRv = 0; nAck = 0; nErr = 0; nEnRd = 0; nEnWr = 0;
      addrQ.delete();
   endtask

   initial begin
      int gapLow, ackFirst, pct;
      modelReset();
      clrCnt();
      @(negedge clkCL);
      compare();
      chk("reset_addr", int'(reg_addr), 'h21);
      resetCL = 1'b0;
      cyc(); cyc();

      // read batch, completion 5 cycles into each transfer
      clrCnt(); gapLow = 0;
      tick_rd = 1'b1; cyc(); tick_rd = 1'b0;
      for (int k = 0; k < 300 && nRv == 0; k++) begin
         seq_done = (inX == 5);
         if (inX == 1) addrQ.push_back(int'(reg_addr));
         if (busy && !en_rd) gapLow++;
         cyc();
      end
      seq_done = 1'b0;
      chk("rd_addr_count", addrQ.size(), 6);
      foreach (addrQ[i]) chk("rd_addr_seq", addrQ[i], 'h21 + i);
      chk("rd_gap_cycles", gapLow, 5);
      chk("rd_enrd_cycles", nEnRd, 30);
      chk("rd_valid_count", nRv, 1);

      // write priority over a simultaneous tick
      clrCnt(); ackFirst = 0;
      tick_rd = 1'b1; wr_req = 1'b1; cyc(); tick_rd = 1'b0;
      chk("prio_en_wr", int'(en_wr), 1);
      chk("prio_en_rd", int'(en_rd), 0);
      for (int k = 0; k < 300 && nRv == 0; k++) begin
         seq_done = (inX == 1);
         cyc();
         if (mAck) wr_req = 1'b0;
         if (nAck == 1 && nRv == 0) ackFirst = 1;
      end
      seq_done = 1'b0;
      chk("prio_ack_first", ackFirst, 1);
      chk("prio_ack_count", nAck, 1);
      chk("prio_rv_count", nRv, 1);

      // timeout at idx 2, then restart with wr_req still high
      clrCnt(); wr_req = 1'b1;
      for (int k = 0; k < 400 && nErr == 0; k++) begin
         seq_done = (inX == 2 && mIdx < 2);
         cyc();
      end
      seq_done = 1'b0;
      chk("tmo_err_count", nErr, 1);
      chk("tmo_enwr_cycles", nEnWr, 2 + 2 + 31);
      chk("tmo_busy", int'(busy), 0);
      chk("tmo_addr", int'(reg_addr), 'h21);
      cyc();
      chk("tmo_restart_en", int'(en_wr), 1);
      chk("tmo_restart_addr", int'(reg_addr), 'h21);
      for (int k = 0; k < 300 && nAck == 0; k++) begin
         seq_done = (inX == 1);
         cyc();
         if (mAck) wr_req = 1'b0;
      end
      seq_done = 1'b0;
      chk("tmo_ack_count", nAck, 1);

      // completion on the last allowed cycle beats the timeout
      clrCnt(); wr_req = 1'b1;
      for (int k = 0; k < 300 && nAck == 0; k++) begin
         seq_done = (mIdx == 0) ? (inX == 31) : (inX == 1);
         if (seq_done && mIdx == 0) begin
            cyc();
            chk("col_gap_addr", int'(reg_addr), 'h22);
            chk("col_gap_en", int'(en_wr), 0);
         end else cyc();
         if (mAck) wr_req = 1'b0;
      end
      seq_done = 1'b0;
      chk("col_err_count", nErr, 0);
      chk("col_enwr_cycles", nEnWr, 31 + 5);
      chk("col_ack_count", nAck, 1);

      // three ticks during a write yield one read batch
      clrCnt(); wr_req = 1'b1;
      for (int k = 0; k < 200 && nAck == 0; k++) begin
         tick_rd = (k == 3 || k == 8 || k == 15);
         seq_done = (inX == 2);
         cyc();
         if (mAck) wr_req = 1'b0;
      end
      tick_rd = 1'b0;
      for (int k = 0; k < 150; k++) begin
         seq_done = (inX == 2);
         cyc();
      end
      seq_done = 1'b0;
      chk("ovf_rv_count", nRv, 1);
      chk("ovf_enrd_cycles", nEnRd, 12);

      // asynchronous reset in the middle of a read at idx 3
      clrCnt();
      tick_rd = 1'b1; cyc(); tick_rd = 1'b0;
      for (int k = 0; k < 200 && !(mIdx == 3 && inX == 2); k++) begin
         seq_done = (inX == 2);
         cyc();
      end
      seq_done = 1'b0;
      chk("rst_reached_idx3", int'(reg_addr), 'h24);
      #2 resetCL = 1'b1;
      #1;
      chk("rst_en_rd", int'(en_rd), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_addr", int'(reg_addr), 'h21);
      modelReset();
      cyc();
      resetCL = 1'b0;
      for (int k = 0; k < 10; k++) cyc();
      chk("rst_no_rv", nRv, 0);
      tick_rd = 1'b1; cyc(); tick_rd = 1'b0;
      for (int k = 0; k < 200 && nRv == 0; k++) begin
         seq_done = (inX == 3);
         if (inX == 1) addrQ.push_back(int'(reg_addr));
         cyc();
      end
      seq_done = 1'b0;
      chk("rst_batch_regs", addrQ.size(), 6);
      if (addrQ.size() > 0) chk("rst_batch_first", addrQ[0], 'h21);
      chk("rst_batch_rv", nRv, 1);

      // randomized traffic
      pct = 50;
      for (int k = 0; k < 4000; k++) begin
         if (k % 300 == 0) begin
            case ($urandom_range(3))
               0: pct = 0;
               1: pct = 20;
               2: pct = 50;
               default: pct = 90;
            endcase
         end
         tick_rd  = ($urandom_range(19) == 0);
         seq_done = ($urandom_range(99) < pct);
         if (mAck) wr_req = 1'b0;
         else if (mErr) wr_req = wr_req & $urandom_range(1);
         else if (!wr_req && $urandom_range(39) == 0) wr_req = 1'b1;
         if ($urandom_range(1499) == 0) begin
            #2 resetCL = 1'b1;
            modelReset();
            cyc();
            resetCL = 1'b0;
         end else cyc();
      end
      tick_rd = 1'b0; seq_done = 1'b0; wr_req = 1'b0;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
